flight_ctrl: RTL and testbench
==============================

// Module: flight_ctrl
// PURPOSE
//  Game sequencer for the AUTOCROSS player sprite: consumes the paced up/down move ticks
//  from the key pacing block, arbitrates them, and owns player Y position, game state,
//  score and difficulty level. Sits between key pacing and the VGA renderer/collision logic.
// PARAMETERS
//  Y_MIN      0    topmost legal Y (screen Y grows downward)
//  Y_MAX      440  floor Y; reaching it on a fall = crash
//  Y_START    240  Y loaded in IDLE
//  STEP_UP    8    pixels moved per up tick
//  STEP_DN    4    pixels moved per down tick
//  HIT_HOLD   1000 cycles spent in HIT before OVER (>=2)
//  LVL_PASSES 10   obstacle passes per level increment
// PORTS
//  clk            in   1   system clock
//  reset          in   1   asynchronous, active-low reset
//  start          in   1   start/restart button, level, asynchronous to game ticks
//  up_key_press   in   1   one-cycle up tick from key pacing
//  down_key_press in   1   one-cycle down tick from key pacing
//  collide        in   1   sprite/obstacle overlap from renderer, level
//  pass           in   1   one-cycle pulse: obstacle cleared
//  y_pos          out  10  player Y
//  state          out  2   00 IDLE, 01 RUN, 10 HIT, 11 OVER
//  move_en        out  1   1 only in RUN; gates key pacing
//  hit_flash      out  1   blink for sprite in HIT
//  score          out  14  passes this game, saturates at 9999
//  level          out  2   difficulty, saturates at 3
// BEHAVIOUR
//  Reset (async, reset=0): state=IDLE, y_pos=Y_START, score=0, level=0, pass sub-count=0,
//   hit counter=0, move_en=0, hit_flash=0, start history=0. All outputs registered.
//  start_rise = start & ~start_q (start_q registered); 1-cycle latency from press.
//  IDLE: y_pos held at Y_START, score/level cleared. start_rise -> RUN next cycle.
//  RUN (per cycle):
//   - collide=1 -> HIT next cycle; y_pos frozen at current value, ticks this cycle ignored.
//   - else up_key_press=1 (wins if both ticks same cycle; down tick dropped):
//     y_pos <= (y_pos < Y_MIN+STEP_UP) ? Y_MIN : y_pos-STEP_UP (clamp, no wrap).
//   - else down_key_press=1: y_pos <= min(y_pos+STEP_DN, Y_MAX);
//     if the new value == Y_MAX -> HIT next cycle (floor crash).
//   - pass=1 (independent of ticks, also on a collide cycle): score <= min(score+1, 9999);
//     sub-count increments; at LVL_PASSES-1 it wraps to 0 and level <= min(level+1,3).
//   - start_rise ignored in RUN.
//  HIT: y_pos frozen; hit counter counts 0..HIT_HOLD-1, then -> OVER, counter cleared.
//   hit_flash = hit counter bit 6; ticks, pass, start ignored.
//  OVER: y_pos, score, level frozen for display; start_rise -> IDLE (clears), a second
//   start_rise -> RUN. collide/pass ignored.
//  move_en = (state==RUN), registered with state; key pacing sees it 1 cycle after entry.
//  Reset asserted mid-game returns to IDLE state values immediately (async).
// STRUCTURE
//  Shared header flight_defs.vh: state encodings (ST_IDLE..ST_OVER), SCORE_MAX=9999,
//   LVL_MAX=3, Y widths. Used by renderer for state/score decode.
//  One sub-module: btn_edge (register + rising-edge pulse), reused for other buttons.
//  Core: 2-bit FSM, Y update mux w/ clamp, score/level counters, hit timer.
// TESTING (HIT_HOLD=200 in bench)
//  Reset, start pulse -> state RUN 2 cycles after press, move_en=1, y_pos=240.
//  RUN, 31 up ticks -> y_pos 0 (clamped, no wrap); up+down same cycle at y=100 -> 92.
//  RUN from 240, 50 down ticks -> y_pos 440, state HIT, y frozen; 200 cycles -> OVER.
//  collide=1 at y=200 with up tick same cycle -> HIT, y_pos stays 200.
//  25 pass pulses -> score 25, level 2; force 9999 -> score holds 9999; level stays 3.
//  OVER: start -> IDLE (score 0, y 240), start -> RUN; reset mid-RUN -> IDLE values.

Source files
------------

// File: rtl/flight_ctrl_pkg.sv
// Shared types and limits for the flight sequencer.
// Also used by the renderer to decode state and score.
package flight_ctrl_pkg;

  localparam int YW = 10;
  localparam int SW = 14;
  localparam int LW = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HIT  = 2'b10,
    ST_OVER = 2'b11
  } state_e;

  localparam logic [SW-1:0] SCORE_MAX = 14'd9999;
  localparam logic [LW-1:0] LVL_MAX   = 2'd3;

endpackage

// File: rtl/flight_ctrl_if.sv
// Player/game bus: move ticks and game events in,
// sprite position and game status out.
interface flight_ctrl_if;
  import flight_ctrl_pkg::*;

  logic          start;
  logic          up_key_press;
  logic          down_key_press;
  logic          collide;
  logic          pass;
  logic [YW-1:0] y_pos;
  logic [1:0]    state;
  logic          move_en;
  logic          hit_flash;
  logic [SW-1:0] score;
  logic [LW-1:0] level;

  modport master (
    output start, up_key_press, down_key_press,
    output collide, pass,
    input  y_pos, state, move_en, hit_flash,
    input  score, level
  );

  modport slave (
    input  start, up_key_press, down_key_press,
    input  collide, pass,
    output y_pos, state, move_en, hit_flash,
    output score, level
  );

endinterface

// File: rtl/btn_edge.sv
// Button history register plus registered rising-edge pulse.
// Ports: clk, reset (async active-low), btn in, rise out.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic rise
);

  logic btn_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_q <= 1'b0;
      rise  <= 1'b0;
    end else begin
      btn_q <= btn;
      rise  <= btn & ~btn_q;
    end
  end

endmodule

// File: rtl/flight_ctrl.sv
// Game sequencer: player Y, game FSM, score/level, hit timer.
// Ports: clk, reset (async active-low), bus (flight_ctrl_if.slave).
module flight_ctrl
  import flight_ctrl_pkg::*;
#(
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 440,
  parameter int Y_START    = 240,
  parameter int STEP_UP    = 8,
  parameter int STEP_DN    = 4,
  parameter int HIT_HOLD   = 1000,
  parameter int LVL_PASSES = 10
) (
  input logic          clk,
  input logic          reset,
  flight_ctrl_if.slave bus
);

  localparam int SUBW = $clog2(LVL_PASSES);
  localparam int HCL  = $clog2(HIT_HOLD);
  // Counter keeps at least 7 bits so the flash bit exists.
  localparam int HCW  = (HCL > 7) ? HCL : 7;

  localparam logic [YW-1:0] YMIN   = YW'(Y_MIN);
  localparam logic [YW-1:0] YMAX   = YW'(Y_MAX);
  localparam logic [YW-1:0] YSTART = YW'(Y_START);
  localparam logic [YW-1:0] STUP   = YW'(STEP_UP);
  localparam logic [YW-1:0] STDN   = YW'(STEP_DN);
  localparam logic [SUBW-1:0] SUB_LAST = SUBW'(LVL_PASSES - 1);
  localparam logic [HCW-1:0]  HIT_LAST = HCW'(HIT_HOLD - 1);

  state_e          st_q, st_d;
  logic [YW-1:0]   y_q, y_d, y_up, y_dn;
  logic [YW:0]     y_sum;
  logic [SW-1:0]   sc_q, sc_d;
  logic [LW-1:0]   lv_q, lv_d;
  logic [SUBW-1:0] sub_q, sub_d;
  logic [HCW-1:0]  hit_q, hit_d;
  logic            men_q, fl_q;
  logic            start_rise;
  logic            mv_up, mv_dn;
  logic            crash, hit_done;

  btn_edge u_start (
    .clk   (clk),
    .reset (reset),
    .btn   (bus.start),
    .rise  (start_rise)
  );

  // Collide beats both ticks; up beats down.
  assign mv_up = ~bus.collide & bus.up_key_press;
  assign mv_dn = ~bus.collide & ~bus.up_key_press
               & bus.down_key_press;

  always_comb begin
    y_up  = (y_q < YMIN + STUP) ? YMIN : y_q - STUP;
    y_sum = {1'b0, y_q} + {1'b0, STDN};
    y_dn  = (y_sum >= {1'b0, YMAX}) ? YMAX
                                    : y_sum[YW-1:0];
  end

  assign crash    = mv_dn & (y_dn == YMAX);
  assign hit_done = (hit_q == HIT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) st_q <= ST_IDLE;
    else        st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      ST_IDLE: if (start_rise) st_d = ST_RUN;
      ST_RUN:  if (bus.collide | crash) st_d = ST_HIT;
      ST_HIT:  if (hit_done) st_d = ST_OVER;
      ST_OVER: if (start_rise) st_d = ST_IDLE;
      default: st_d = ST_IDLE;
    endcase
  end

  always_comb begin
    y_d   = y_q;
    sc_d  = sc_q;
    lv_d  = lv_q;
    sub_d = sub_q;
    hit_d = hit_q;
    unique case (st_q)
      ST_RUN: begin
        unique case (1'b1)
          mv_up:   y_d = y_up;
          mv_dn:   y_d = y_dn;
          default: y_d = y_q;
        endcase
        if (bus.pass) begin
          if (sc_q != SCORE_MAX) sc_d = sc_q + 1'b1;
          if (sub_q == SUB_LAST) begin
            sub_d = '0;
            if (lv_q != LVL_MAX) lv_d = lv_q + 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
      end
      ST_HIT: hit_d = hit_done ? '0 : hit_q + 1'b1;
      default: ;
    endcase
    // Entering or sitting in IDLE loads fresh game values.
    if (st_d == ST_IDLE) begin
      y_d   = YSTART;
      sc_d  = '0;
      lv_d  = '0;
      sub_d = '0;
      hit_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q   <= YSTART;
      sc_q  <= '0;
      lv_q  <= '0;
      sub_q <= '0;
      hit_q <= '0;
      men_q <= 1'b0;
      fl_q  <= 1'b0;
    end else begin
      y_q   <= y_d;
      sc_q  <= sc_d;
      lv_q  <= lv_d;
      sub_q <= sub_d;
      hit_q <= hit_d;
      men_q <= (st_d == ST_RUN);
      fl_q  <= hit_d[6];
    end
  end

  assign bus.y_pos     = y_q;
  assign bus.state     = st_q;
  assign bus.move_en   = men_q;
  assign bus.hit_flash = fl_q;
  assign bus.score     = sc_q;
  assign bus.level     = lv_q;

endmodule

// File: tb/tb_flight_ctrl.sv
// Self-checking bench for flight_ctrl: directed scenarios
// plus random stimulus against a behavioural game model.
module tb_flight_ctrl;

  localparam int HH = 200;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int checks = 0;
  int failures = 0;

  flight_ctrl_if bus ();

  flight_ctrl #(.HIT_HOLD(HH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  int m_st, m_y, m_sc, m_lv, m_sub, m_hit;
  bit m_sq, m_rise;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_y = 240; m_sc = 0; m_lv = 0;
    m_sub = 0; m_hit = 0; m_sq = 0; m_rise = 0;
  endtask

  task automatic model_clk(input bit s, u, d, c, p);
    bit r;
    int nst;
    r = m_rise;
    nst = m_st;
    m_rise = s && !m_sq;
    m_sq = s;
    case (m_st)
      0: if (r) nst = 1;
      1: begin
        if (c) nst = 2;
        else if (u) m_y = (m_y < 8) ? 0 : m_y - 8;
        else if (d) begin
          m_y = (m_y + 4 > 440) ? 440 : m_y + 4;
          if (m_y == 440) nst = 2;
        end
        if (p) begin
          m_sc = (m_sc < 9999) ? m_sc + 1 : 9999;
          m_sub++;
          if (m_sub == 10) begin
            m_sub = 0;
            m_lv = (m_lv < 3) ? m_lv + 1 : 3;
          end
        end
      end
      2: begin
        if (m_hit == HH - 1) begin
          m_hit = 0;
          nst = 3;
        end else m_hit++;
      end
      default: if (r) nst = 0;
    endcase
    if (nst == 0) begin
      m_y = 240; m_sc = 0; m_lv = 0;
      m_sub = 0; m_hit = 0;
    end
    m_st = nst;
  endtask

  task automatic chk_all();
    chk("state", 32'(bus.state), m_st);
    chk("y_pos", 32'(bus.y_pos), m_y);
    chk("score", 32'(bus.score), m_sc);
    chk("level", 32'(bus.level), m_lv);
    chk("move_en", 32'(bus.move_en), (m_st == 1) ? 1 : 0);
    chk("hit_flash", 32'(bus.hit_flash),
        (m_st == 2) ? ((m_hit >> 6) & 1) : 0);
  endtask

  // Called at a falling edge: drive, clock, model, check.
  task automatic step(input bit s, u, d, c, p);
    bus.start = s;
    bus.up_key_press = u;
    bus.down_key_press = d;
    bus.collide = c;
    bus.pass = p;
    @(posedge clk);
    model_clk(s, u, d, c, p);
    @(negedge clk);
    chk_all();
  endtask

  task automatic press();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
  endtask

  task automatic hold_hit();
    for (int i = 0; i < HH; i++)
      step(0, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
  endtask

  initial begin
    bus.start = 0;
    bus.up_key_press = 0;
    bus.down_key_press = 0;
    bus.collide = 0;
    bus.pass = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_y", 32'(bus.y_pos), 240);
    chk("rst_move_en", 32'(bus.move_en), 0);
    reset = 1'b1;
    @(negedge clk);

    // Start: RUN two cycles after press
    step(1, 0, 0, 0, 0);
    chk("start_lat1", 32'(bus.state), 0);
    step(1, 0, 0, 0, 0);
    chk("start_run", 32'(bus.state), 1);
    chk("start_men", 32'(bus.move_en), 1);
    chk("start_y", 32'(bus.y_pos), 240);
    step(0, 0, 0, 0, 0);

    // Up clamp at top
    repeat (31) step(0, 1, 0, 0, 0);
    chk("up_clamp", 32'(bus.y_pos), 0);
    repeat (25) step(0, 0, 1, 0, 0);
    chk("y_100", 32'(bus.y_pos), 100);
    step(0, 1, 1, 0, 0);
    chk("up_wins", 32'(bus.y_pos), 92);

    // Floor crash
    repeat (37) step(0, 0, 1, 0, 0);
    chk("y_240", 32'(bus.y_pos), 240);
    repeat (50) step(0, 0, 1, 0, 0);
    chk("crash_y", 32'(bus.y_pos), 440);
    chk("crash_hit", 32'(bus.state), 2);
    for (int i = 0; i < HH - 1; i++)
      step(0, 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    chk("hit_hold", 32'(bus.state), 2);
    chk("hit_frozen", 32'(bus.y_pos), 440);
    step(0, 1, 0, 0, 0);
    chk("over", 32'(bus.state), 3);

    // OVER -> IDLE -> RUN
    press();
    chk("over_idle", 32'(bus.state), 0);
    chk("idle_score", 32'(bus.score), 0);
    chk("idle_y", 32'(bus.y_pos), 240);
    press();
    chk("rerun", 32'(bus.state), 1);

    // Collide with up tick same cycle
    repeat (5) step(0, 1, 0, 0, 0);
    step(0, 1, 0, 1, 1);
    chk("coll_hit", 32'(bus.state), 2);
    chk("coll_y", 32'(bus.y_pos), 200);
    chk("coll_pass", 32'(bus.score), 1);
    hold_hit();
    chk("coll_over", 32'(bus.state), 3);
    press();
    press();

    // Score and level
    repeat (25) step(0, 0, 0, 0, 1);
    chk("score25", 32'(bus.score), 25);
    chk("level2", 32'(bus.level), 2);
    repeat (9974) step(0, 0, 0, 0, 1);
    chk("score_max", 32'(bus.score), 9999);
    step(0, 0, 0, 0, 1);
    chk("score_sat", 32'(bus.score), 9999);
    chk("level_sat", 32'(bus.level), 3);

    // Async reset mid-RUN
    repeat (3) step(0, 1, 0, 0, 0);
    #2 reset = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state), 0);
    chk("arst_y", 32'(bus.y_pos), 240);
    chk("arst_score", 32'(bus.score), 0);
    chk("arst_level", 32'(bus.level), 0);
    chk("arst_men", 32'(bus.move_en), 0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Random play
    begin
      bit s = 0;
      for (int i = 0; i < 4000; i++) begin
        if ($urandom_range(0, 29) == 0) s = ~s;
        step(s, ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0),
             ($urandom_range(0, 39) == 0),
             ($urandom_range(0, 4) == 0));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
